// File: rtl/vga_scan_controller.sv
// vga_scan_controller: 640x480@60 raster counters, latency-matched sync/blank and 3-bit to 24-bit colour for the DAC
module vga_scan_controller #(
    parameter int CLK_DIV  = 2,
    parameter int PIPE_LAT = 1,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] color_in,
    input  logic       visible_in,
    output logic [9:0] pixelx,
    output logic [9:0] pixely,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int D     = PIPE_LAT > 0 ? PIPE_LAT : 1;
    logic [DW-1:0] div;
    logic [9:0]    x_n, y_n, sx, sy;
    logic          last_x, last_y, hs_raw, vs_raw, act_raw, act_d;
    logic [2:0]    stage [D];
    logic [2:0]    nxt   [D];
    assign pix_tick    = div == DW'(CLK_DIV - 1);
    assign vga_clk     = 2 * int'(div) < CLK_DIV;
    assign vga_sync_n  = 1'b0;
    assign vga_hsync   = stage[D-1][2];
    assign vga_vsync   = stage[D-1][1];
    assign vga_blank_n = stage[D-1][0];
    always_comb begin
        last_x  = pixelx == 10'(H_TOT - 1);
        last_y  = pixely == 10'(V_TOT - 1);
        x_n     = last_x ? '0 : pixelx + 10'd1;
        y_n     = last_x ? (last_y ? '0 : pixely + 10'd1) : pixely;
        sx      = PIPE_LAT == 0 ? x_n : pixelx;
        sy      = PIPE_LAT == 0 ? y_n : pixely;
        hs_raw  = !(sx >= 10'(H_VIS + H_FP) && sx < 10'(H_VIS + H_FP + H_SYNC));
        vs_raw  = !(sy >= 10'(V_VIS + V_FP) && sy < 10'(V_VIS + V_FP + V_SYNC));
        act_raw = sx < 10'(H_VIS) && sy < 10'(V_VIS);
        nxt[0]  = {hs_raw, vs_raw, act_raw};
        for (int i = 1; i < D; i++) nxt[i] = stage[i-1];
        act_d   = nxt[D-1][0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            div         <= '0;
            pixelx      <= '0;
            pixely      <= '0;
            frame_start <= 1'b0;
            stage       <= '{default: 3'b110};
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            div         <= pix_tick ? '0 : div + 1'b1;
            frame_start <= pix_tick && last_x && last_y;
            if (pix_tick) begin
                pixelx <= x_n;
                pixely <= y_n;
                stage  <= nxt;
                vga_r  <= {8{act_d & visible_in & color_in[2]}};
                vga_g  <= {8{act_d & visible_in & color_in[1]}};
                vga_b  <= {8{act_d & visible_in & color_in[0]}};
            end
        end
    end
endmodule
